// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
// Holds forwarding select codes, the writeback-select code for loads, FSM state
// encodings, the shadow-slot structs for M and W, and the register-hit helper.
package hazard_sequencer_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from wb_resultW
  localparam logic [1:0] FWD_ALU = 2'b10;  // operand from alu_outM

  localparam logic [1:0] WB_SEL_MEM = 2'b00;  // writeback takes memory data (load)

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  // Shadow of the instruction occupying the execute (M) slot.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       load;
    logic       mem;
  } m_slot_t;

  // Shadow of the instruction occupying the writeback (W) slot.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
  } w_slot_t;

  // A source register matches a slot's destination; x0 never matches.
  function automatic logic slot_hit(input logic [4:0] adr, input logic valid,
                                    input logic wen, input logic [4:0] rd);
    return (adr != 5'd0) && valid && wen && (rd == adr);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Purpose: decode-stage forwarding selects and raw load-use detection.
// Latency: purely combinational, no state.
// Backpressure: none; the sequencer decides whether load_use may act.
// Ports: adr1/adr2 decode source indices; m_slot/w_slot shadow slots;
//        forward1/forward2 operand selects; load_use raw load-use hazard.
module hazard_fwd_unit
  import hazard_sequencer_pkg::*;
(
  input  logic [4:0] adr1,
  input  logic [4:0] adr2,
  input  m_slot_t    m_slot,
  input  w_slot_t    w_slot,
  output logic [1:0] forward1,
  output logic [1:0] forward2,
  output logic       load_use
);

  logic hit1_m, hit2_m, hit1_w, hit2_w;

  always_comb begin
    hit1_m = slot_hit(adr1, m_slot.valid, m_slot.wen, m_slot.rd);
    hit2_m = slot_hit(adr2, m_slot.valid, m_slot.wen, m_slot.rd);
    hit1_w = slot_hit(adr1, w_slot.valid, w_slot.wen, w_slot.rd);
    hit2_w = slot_hit(adr2, w_slot.valid, w_slot.wen, w_slot.rd);

    // M has priority; a load in M has no ALU result to forward, so it falls
    // through to W (the load-use stall covers that case).
    forward1 = FWD_RF;
    if (hit1_m && !m_slot.load) forward1 = FWD_ALU;
    else if (hit1_w)            forward1 = FWD_WB;

    forward2 = FWD_RF;
    if (hit2_m && !m_slot.load) forward2 = FWD_ALU;
    else if (hit2_w)            forward2 = FWD_WB;

    load_use = (hit1_m || hit2_m) && m_slot.load;
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Purpose: pipeline control for the 3-stage core: forwarding, load-use stall, flush, memory wait.
// Latency: all outputs combinational from decode inputs and registered M/W shadow + FSM state.
// Backpressure: dmem_ready low freezes F/D/M; MAX_WAIT not-ready cycles latch a sticky fault.
// Ports: clk, rst (async active-low); decode fields adr1D/adr2D/rdD/reg_writeD/mem_accessD/
//        wb_selD/pc_selD; dmem_ready; outputs forward1D/2D, stall_f/d/m, bubble_m, flush_d,
//        dmem_req, mem_fault.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] adr1D,
  input  logic [4:0] adr2D,
  input  logic [4:0] rdD,
  input  logic       reg_writeD,
  input  logic       mem_accessD,
  input  logic [1:0] wb_selD,
  input  logic [1:0] pc_selD,
  input  logic       dmem_ready,
  output logic [1:0] forward1D,
  output logic [1:0] forward2D,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_m,
  output logic       bubble_m,
  output logic       flush_d,
  output logic       dmem_req,
  output logic       mem_fault
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d, cnt_inc;
  m_slot_t           m_q, m_d;
  w_slot_t           w_q, w_d;
  logic              lu_raw, lu, freeze;

  hazard_fwd_unit u_fwd (
    .adr1     (adr1D),
    .adr2     (adr2D),
    .m_slot   (m_q),
    .w_slot   (w_q),
    .forward1 (forward1D),
    .forward2 (forward2D),
    .load_use (lu_raw)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      m_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      w_q     <= w_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    freeze   = 1'b0;
    lu       = 1'b0;
    cnt_inc  = cnt_q + WAIT_W'(1);
    dmem_req = m_q.valid && m_q.mem && (state_q != ST_FAULT);

    case (state_q)
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
          cnt_d   = WAIT_W'(1);
        end else begin
          lu = lu_raw;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          // The access completes and the pipeline advances this edge. A load
          // finishing here still cannot feed a dependent in decode, so the
          // load-use bubble applies on this release cycle as well.
          state_d = ST_RUN;
          cnt_d   = '0;
          lu      = lu_raw;
        end else begin
          freeze = 1'b1;
          cnt_d  = cnt_inc;
          // cnt_inc counts every consecutive not-ready cycle, including the
          // RUN cycle that opened the wait.
          if (cnt_inc >= MAX_CNT) state_d = ST_FAULT;
        end
      end
      ST_FAULT: freeze = 1'b1;
      default:  state_d = ST_RUN;
    endcase

    mem_fault = (state_q == ST_FAULT);
    stall_f   = freeze || lu;
    stall_d   = freeze || lu;
    stall_m   = freeze;
    bubble_m  = lu;
    // A redirect seen during a stall is dropped; decode re-presents it later.
    flush_d   = (pc_selD != 2'b00) && !freeze && !lu;

    m_d = m_q;
    w_d = w_q;
    if (!freeze) begin
      w_d = '{valid: m_q.valid, rd: m_q.rd, wen: m_q.wen};
      if (lu) begin
        m_d = '0;
      end else begin
        m_d = '{valid: 1'b1, rd: rdD, wen: reg_writeD,
                load: mem_accessD && (wb_selD == WB_SEL_MEM), mem: mem_accessD};
      end
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer with MAX_WAIT = 4.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// ctl packs {stall_f, stall_d, stall_m, bubble_m, flush_d, dmem_req, mem_fault}.
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] adr1D, adr2D, rdD;
  logic       reg_writeD, mem_accessD;
  logic [1:0] wb_selD, pc_selD;
  logic       dmem_ready;
  logic [1:0] forward1D, forward2D;
  logic       stall_f, stall_d, stall_m, bubble_m, flush_d, dmem_req, mem_fault;
  logic [6:0] ctl;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign ctl = {stall_f, stall_d, stall_m, bubble_m, flush_d, dmem_req, mem_fault};

  hazard_sequencer #(.WAIT_W(8), .MAX_WAIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .adr1D       (adr1D),
    .adr2D       (adr2D),
    .rdD         (rdD),
    .reg_writeD  (reg_writeD),
    .mem_accessD (mem_accessD),
    .wb_selD     (wb_selD),
    .pc_selD     (pc_selD),
    .dmem_ready  (dmem_ready),
    .forward1D   (forward1D),
    .forward2D   (forward2D),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .stall_m     (stall_m),
    .bubble_m    (bubble_m),
    .flush_d     (flush_d),
    .dmem_req    (dmem_req),
    .mem_fault   (mem_fault)
  );

  task automatic dec(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                     input logic wen, input logic mem, input logic [1:0] wb, input logic [1:0] pc);
    adr1D = a1; adr2D = a2; rdD = rd;
    reg_writeD = wen; mem_accessD = mem; wb_selD = wb; pc_selD = pc;
  endtask

  task automatic nop();
    dec(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 2'b00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; dmem_ready = 1'b1; nop();
    #12;
    vecs++;
    if (ctl !== 7'b0000000 || forward1D !== 2'b00 || forward2D !== 2'b00) begin
      errs++; $display("FAIL reset_outputs: ctl=%b fwd1=%b fwd2=%b, required ctl=0000000 fwd=00", ctl, forward1D, forward2D);
    end
    tick(); rst = 1'b1;
    @(negedge clk);
    vecs++;
    if (ctl !== 7'b0000000) begin
      errs++; $display("FAIL reset_release: ctl=%b required 0000000", ctl);
    end
    tick();
  endtask

  task automatic test_forward();
    nop(); tick(); tick();
    dec(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 2'b01, 2'b00);          // add x5
    tick();
    dec(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 2'b01, 2'b00);          // uses x5, writes x5
    @(negedge clk);
    vecs++;
    if (forward1D !== 2'b10 || ctl !== 7'b0000000) begin
      errs++; $display("FAIL fwd_from_m: fwd1=%b ctl=%b, required 10 / 0000000", forward1D, ctl);
    end
    tick();
    dec(5'd5, 5'd0, 5'd9, 1'b1, 1'b0, 2'b01, 2'b00);          // x5 in both M and W
    @(negedge clk);
    vecs++;
    if (forward1D !== 2'b10) begin
      errs++; $display("FAIL fwd_m_priority: fwd1=%b required 10", forward1D);
    end
    tick();
    dec(5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 2'b01, 2'b00);          // x5 only in W now
    @(negedge clk);
    vecs++;
    if (forward2D !== 2'b01 || forward1D !== 2'b00) begin
      errs++; $display("FAIL fwd_from_w: fwd2=%b fwd1=%b, required 01 / 00", forward2D, forward1D);
    end
    tick();
  endtask

  task automatic test_load_use();
    nop(); tick(); tick();
    dec(5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 2'b00, 2'b00);          // lw x6
    tick();
    dec(5'd0, 5'd6, 5'd8, 1'b1, 1'b0, 2'b01, 2'b00);          // uses x6
    @(negedge clk);
    vecs++;
    if (ctl !== 7'b1101010 || forward2D !== 2'b00) begin
      errs++; $display("FAIL load_use_stall: ctl=%b fwd2=%b, required 1101010 / 00", ctl, forward2D);
    end
    tick();
    @(negedge clk);
    vecs++;
    if (ctl !== 7'b0000000 || forward2D !== 2'b01) begin
      errs++; $display("FAIL load_use_resolve: ctl=%b fwd2=%b, required 0000000 / 01", ctl, forward2D);
    end
    tick();
    nop();
    @(negedge clk);
    vecs++;
    if (ctl !== 7'b0000000) begin
      errs++; $display("FAIL load_use_once: ctl=%b required 0000000", ctl);
    end
    tick();
  endtask

  task automatic test_x0();
    nop(); tick(); tick();
    dec(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 2'b01, 2'b00);          // writes x0
    tick();
    dec(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 2'b00);          // lw x0, reads x0
    @(negedge clk);
    vecs++;
    if (forward1D !== 2'b00 || ctl !== 7'b0000000) begin
      errs++; $display("FAIL x0_alu_dest: fwd1=%b ctl=%b, required 00 / 0000000", forward1D, ctl);
    end
    tick();
    nop();
    @(negedge clk);
    vecs++;
    if (forward1D !== 2'b00 || forward2D !== 2'b00 || ctl !== 7'b0000010) begin
      errs++; $display("FAIL x0_load_dest: fwd=%b%b ctl=%b, required 0000 / 0000010", forward1D, forward2D, ctl);
    end
    tick();
  endtask

  task automatic test_flush();
    nop(); tick(); tick();
    dec(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 2'b01);          // taken branch
    @(negedge clk);
    vecs++;
    if (ctl !== 7'b0000100) begin
      errs++; $display("FAIL flush_plain: ctl=%b required 0000100", ctl);
    end
    tick();
    dec(5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 2'b00, 2'b00);          // lw x6
    @(negedge clk);
    vecs++;
    if (flush_d !== 1'b0) begin
      errs++; $display("FAIL flush_one_cycle: flush_d=%b required 0", flush_d);
    end
    tick();
    dec(5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 2'b01);          // branch on x6
    @(negedge clk);
    vecs++;
    if (ctl !== 7'b1101010) begin
      errs++; $display("FAIL flush_deferred: ctl=%b required 1101010", ctl);
    end
    tick();
    @(negedge clk);
    vecs++;
    if (ctl !== 7'b0000100 || forward1D !== 2'b01) begin
      errs++; $display("FAIL flush_after_stall: ctl=%b fwd1=%b, required 0000100 / 01", ctl, forward1D);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    nop(); tick(); tick();
    dec(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 2'b01, 2'b00);          // store
    tick();
    nop(); dmem_ready = 1'b0;
    @(negedge clk);
    vecs++;
    if (ctl !== 7'b1110010) begin
      errs++; $display("FAIL wait_cycle1: ctl=%b required 1110010", ctl);
    end
    tick();
    pc_selD = 2'b01;
    for (int i = 2; i <= 3; i++) begin
      @(negedge clk);
      vecs++;
      if (ctl !== 7'b1110010) begin
        errs++; $display("FAIL wait_cycle%0d: ctl=%b required 1110010", i, ctl);
      end
      tick();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    vecs++;
    if (ctl !== 7'b0000110) begin
      errs++; $display("FAIL wait_release: ctl=%b required 0000110", ctl);
    end
    tick();
    nop();
    @(negedge clk);
    vecs++;
    if (ctl !== 7'b0000000 || dut.state_q !== 2'd0) begin
      errs++; $display("FAIL wait_back_to_run: ctl=%b state=%0d, required 0000000 / 0", ctl, dut.state_q);
    end
    tick();
  endtask

  task automatic test_fault();
    nop(); tick(); tick();
    dec(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 2'b01, 2'b00);          // store
    tick();
    nop(); dmem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      vecs++;
      if (ctl !== 7'b1110010) begin
        errs++; $display("FAIL fault_wait%0d: ctl=%b required 1110010", i, ctl);
      end
      tick();
    end
    pc_selD = 2'b10;
    @(negedge clk);
    vecs++;
    if (ctl !== 7'b1110001) begin
      errs++; $display("FAIL fault_entry: ctl=%b required 1110001", ctl);
    end
    tick();
    nop(); dmem_ready = 1'b1;
    tick();
    @(negedge clk);
    vecs++;
    if (ctl !== 7'b1110001) begin
      errs++; $display("FAIL fault_sticky: ctl=%b required 1110001", ctl);
    end
    tick();
    #2 rst = 1'b0;
    #1;
    vecs++;
    if (ctl !== 7'b0000000 || forward1D !== 2'b00 || forward2D !== 2'b00) begin
      errs++; $display("FAIL fault_async_reset: ctl=%b fwd=%b%b, required 0000000 / 0000", ctl, forward1D, forward2D);
    end
    tick(); rst = 1'b1;
    tick();
    @(negedge clk);
    vecs++;
    if (ctl !== 7'b0000000) begin
      errs++; $display("FAIL fault_no_reissue: ctl=%b required 0000000", ctl);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_x0();
    test_flush();
    test_mem_wait();
    test_fault();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
